// File: rtl/conv_out_serializer.sv
// Buffers whole pixel words from the conv engine and streams them out one channel per transfer,
// tagging start-of-frame, end-of-line and end-of-frame from the output-map position counters.
module conv_out_serializer #(
  parameter int WIDTH       = 28,
  parameter int HEIGHT      = 28,
  parameter int FILTER_SIZE = 5,
  parameter int DATA_BITS   = 8,
  parameter int CHANNEL_LEN = 3,
  parameter int FIFO_DEPTH  = 4,
  localparam int CH_W       = (CHANNEL_LEN > 1) ? $clog2(CHANNEL_LEN) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_val,
  input  logic [CHANNEL_LEN*DATA_BITS-1:0] data_in,
  output logic                             in_ready,
  output logic [DATA_BITS-1:0]             out_data,
  output logic [CH_W-1:0]                  out_ch,
  output logic                             out_val,
  input  logic                             out_ready,
  output logic                             out_sof,
  output logic                             out_eol,
  output logic                             out_eof,
  output logic                             overflow
);

  localparam int OUT_W  = WIDTH - FILTER_SIZE + 1;
  localparam int OUT_H  = HEIGHT - FILTER_SIZE + 1;
  localparam int WORD_W = CHANNEL_LEN * DATA_BITS;
  localparam int COL_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int ROW_W  = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);

  logic [WORD_W-1:0] mem_reg [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_reg;
  logic [AW:0]       rd_ptr_reg;
  logic [CH_W-1:0]   ch_reg;
  logic [COL_W-1:0]  col_reg;
  logic [ROW_W-1:0]  row_reg;
  logic              overflow_reg;

  logic              empty;
  logic              full;
  logic              last_ch;
  logic              last_col;
  logic              last_row;
  logic              xfer;
  logic              pop;
  logic              push;
  logic [WORD_W-1:0] head;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  assign last_ch  = (ch_reg == CH_W'(CHANNEL_LEN - 1));
  assign last_col = (col_reg == COL_W'(OUT_W - 1));
  assign last_row = (row_reg == ROW_W'(OUT_H - 1));

  assign out_val  = !empty;
  assign xfer     = out_val & out_ready;
  assign pop      = xfer & last_ch;
  assign in_ready = !full | pop;
  assign push     = in_val & in_ready;

  assign head     = mem_reg[rd_ptr_reg[AW-1:0]];
  assign out_data = head[ch_reg*DATA_BITS +: DATA_BITS];
  assign out_ch   = ch_reg;
  assign overflow = overflow_reg;

  assign out_sof  = out_val & (ch_reg == '0) & (col_reg == '0) & (row_reg == '0);
  assign out_eol  = out_val & last_ch & last_col;
  assign out_eof  = out_eol & last_row;

  // Storage has no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      ch_reg       <= '0;
      col_reg      <= '0;
      row_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (in_val && !in_ready) begin
        overflow_reg <= 1'b1;
      end
      if (xfer) begin
        if (last_ch) begin
          ch_reg     <= '0;
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
          if (last_col) begin
            col_reg <= '0;
            row_reg <= last_row ? '0 : row_reg + 1'b1;
          end else begin
            col_reg <= col_reg + 1'b1;
          end
        end else begin
          ch_reg <= ch_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_out_serializer.sv
// Bench for conv_out_serializer: vector table, directed multi-cycle sequences, a small-map tag
// instance and a randomized run against a queue-based reference model.
module tb_conv_out_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_val;
  logic [23:0] data_in;
  logic        in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_val;
  logic        out_ready;
  logic        out_sof, out_eol, out_eof, overflow;

  logic        s_in_val;
  logic [23:0] s_data_in;
  logic        s_in_ready;
  logic [7:0]  s_out_data;
  logic [1:0]  s_out_ch;
  logic        s_out_val;
  logic        s_out_ready;
  logic        s_out_sof, s_out_eol, s_out_eof, s_overflow;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  conv_out_serializer dut (
    .clk(clk), .rst(rst), .in_val(in_val), .data_in(data_in), .in_ready(in_ready),
    .out_data(out_data), .out_ch(out_ch), .out_val(out_val), .out_ready(out_ready),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof), .overflow(overflow)
  );

  conv_out_serializer #(.WIDTH(6), .HEIGHT(6), .FILTER_SIZE(5)) dut_s (
    .clk(clk), .rst(rst), .in_val(s_in_val), .data_in(s_data_in), .in_ready(s_in_ready),
    .out_data(s_out_data), .out_ch(s_out_ch), .out_val(s_out_val), .out_ready(s_out_ready),
    .out_sof(s_out_sof), .out_eol(s_out_eol), .out_eof(s_out_eof), .overflow(s_overflow)
  );

  typedef struct {
    logic        iv;
    logic [23:0] d;
    logic        ordy;
    logic        e_val;
    logic [7:0]  e_data;
    logic [1:0]  e_ch;
    logic        e_sof, e_eol, e_eof, e_irdy, e_ovf;
  } vec_t;

  vec_t        tv [11];
  logic [23:0] w [5];
  logic [23:0] wv;

  // Reference model state for the randomized run
  logic [23:0] mq [$];
  int          mch, xidx, sent, pix, cyc, tcount;
  logic        e_val, e_pop, can_push, prev_stall;
  logic [7:0]  prev_data;
  logic [1:0]  prev_ch;
  logic [23:0] rnd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit check_state);
    rst = 1'b1; in_val = 1'b0; out_ready = 1'b0; data_in = '0;
    tick();
    rst = 1'b0;
    #1;
    if (check_state) begin
      chk("rst_out_val", out_val, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_overflow", overflow, 0);
      chk("rst_tags", {out_sof, out_eol, out_eof}, 0);
    end
  endtask

  // Drain n whole words with out_ready held high, checking bytes in channel order.
  task automatic drain_check(input string nm, input int first, input int n, input logic ovf_exp);
    for (int k = first; k < first + n; k++) begin
      for (int c = 0; c < 3; c++) begin
        in_val = 1'b0; out_ready = 1'b1;
        #1;
        wv = w[k];
        chk($sformatf("%s_val_w%0d_c%0d", nm, k, c), out_val, 1);
        chk($sformatf("%s_data_w%0d_c%0d", nm, k, c), out_data, wv[c*8 +: 8]);
        chk($sformatf("%s_ch_w%0d_c%0d", nm, k, c), out_ch, c);
        chk($sformatf("%s_ovf_w%0d_c%0d", nm, k, c), overflow, ovf_exp);
        tick();
      end
    end
    out_ready = 1'b0;
    #1;
    chk({nm, "_empty"}, out_val, 0);
  endtask

  initial begin
    rst = 1'b1; in_val = 1'b0; data_in = '0; out_ready = 1'b0;
    s_in_val = 1'b0; s_data_in = '0; s_out_ready = 1'b0;
    w[0] = 24'h0C0B0A; w[1] = 24'h1C1B1A; w[2] = 24'h2C2B2A; w[3] = 24'h3C3B3A; w[4] = 24'h4C4B4A;

    //            iv    d            ordy  val   data   ch    sof   eol   eof   irdy  ovf
    tv[0]  = '{1'b1, 24'h030201, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[1]  = '{1'b0, 24'h000000, 1'b1, 1'b1, 8'h01, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[2]  = '{1'b0, 24'h000000, 1'b1, 1'b1, 8'h02, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[3]  = '{1'b0, 24'h000000, 1'b1, 1'b1, 8'h03, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[4]  = '{1'b0, 24'h000000, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[5]  = '{1'b1, 24'h0C0B0A, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[6]  = '{1'b1, 24'h1C1B1A, 1'b0, 1'b1, 8'h0A, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[7]  = '{1'b1, 24'h2C2B2A, 1'b0, 1'b1, 8'h0A, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[8]  = '{1'b1, 24'h3C3B3A, 1'b0, 1'b1, 8'h0A, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[9]  = '{1'b1, 24'h4C4B4A, 1'b0, 1'b1, 8'h0A, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[10] = '{1'b0, 24'h000000, 1'b0, 1'b1, 8'h0A, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    tick();
    do_reset(1'b1);

    // Single word, then fill past capacity with the output stalled
    for (int i = 0; i < 11; i++) begin
      in_val = tv[i].iv; data_in = tv[i].d; out_ready = tv[i].ordy;
      #1;
      chk($sformatf("vec%0d_val", i), out_val, tv[i].e_val);
      if (tv[i].e_val) begin
        chk($sformatf("vec%0d_data", i), out_data, tv[i].e_data);
        chk($sformatf("vec%0d_ch", i), out_ch, tv[i].e_ch);
      end
      chk($sformatf("vec%0d_tags", i), {out_sof, out_eol, out_eof},
          {tv[i].e_sof, tv[i].e_eol, tv[i].e_eof});
      chk($sformatf("vec%0d_in_ready", i), in_ready, tv[i].e_irdy);
      chk($sformatf("vec%0d_overflow", i), overflow, tv[i].e_ovf);
      tick();
    end
    drain_check("ovf_drain", 0, 4, 1'b1);

    // Push into a full FIFO in the same cycle as the last-channel pop
    do_reset(1'b0);
    for (int k = 0; k < 4; k++) begin
      in_val = 1'b1; data_in = w[k]; out_ready = 1'b0;
      #1;
      chk($sformatf("fill_in_ready%0d", k), in_ready, 1);
      tick();
    end
    in_val = 1'b0; out_ready = 1'b1;
    tick(); tick();
    in_val = 1'b1; data_in = w[4]; out_ready = 1'b1;
    #1;
    chk("poppush_ch", out_ch, 2);
    chk("poppush_in_ready", in_ready, 1);
    tick();
    in_val = 1'b0; out_ready = 1'b0;
    #1;
    chk("poppush_overflow", overflow, 0);
    chk("poppush_still_full", in_ready, 0);
    drain_check("popush_drain", 1, 4, 1'b0);

    // Reset in the middle of a pixel with words buffered
    do_reset(1'b0);
    for (int k = 0; k < 3; k++) begin
      in_val = 1'b1; data_in = w[k]; out_ready = 1'b0;
      tick();
    end
    in_val = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    chk("midpix_ch", out_ch, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_out_val", out_val, 0);
    chk("midrst_in_ready", in_ready, 1);
    in_val = 1'b1; data_in = w[3];
    tick();
    in_val = 1'b0;
    #1;
    chk("midrst_next_val", out_val, 1);
    chk("midrst_next_ch", out_ch, 0);
    chk("midrst_next_sof", out_sof, 1);
    chk("midrst_next_data", out_data, 8'h3A);

    // 2x2 output map: tag positions across frame boundary
    do_reset(1'b0);
    tcount = 0;
    for (int c = 0; c < 40; c++) begin
      s_out_ready = 1'b1;
      s_in_val = (c < 5);
      s_data_in = 24'h505050 + 24'(c);
      #1;
      if (s_out_val) begin
        tcount++;
        chk($sformatf("small_eol_t%0d", tcount), s_out_eol, (tcount == 6 || tcount == 12));
        chk($sformatf("small_eof_t%0d", tcount), s_out_eof, (tcount == 12));
        chk($sformatf("small_sof_t%0d", tcount), s_out_sof, (tcount == 1 || tcount == 13));
      end
      tick();
    end
    s_in_val = 1'b0; s_out_ready = 1'b0;
    chk("small_xfer_count", tcount, 15);
    chk("small_overflow", s_overflow, 0);

    // Randomized stream against the queue model
    do_reset(1'b0);
    mq = {}; mch = 0; xidx = 0; sent = 0; prev_stall = 1'b0; cyc = 0;
    while ((sent < 2000 || mq.size() > 0) && cyc < 40000) begin
      cyc++;
      out_ready = 1'($urandom_range(0, 1));
      e_val = (mq.size() > 0);
      e_pop = e_val && out_ready && (mch == 2);
      can_push = (mq.size() < 4) || e_pop;
      in_val = (sent < 2000) && can_push && ($urandom_range(0, 1) == 1);
      rnd = 24'($urandom);
      data_in = rnd;
      #1;
      chk("rnd_val", out_val, e_val);
      chk("rnd_in_ready", in_ready, can_push);
      chk("rnd_overflow", overflow, 0);
      if (e_val) begin
        wv = mq[0];
        pix = xidx / 3;
        chk($sformatf("rnd_data_x%0d", xidx), out_data, wv[mch*8 +: 8]);
        chk($sformatf("rnd_ch_x%0d", xidx), out_ch, mch);
        chk($sformatf("rnd_sof_x%0d", xidx), out_sof, (mch == 0 && (pix % 576) == 0));
        chk($sformatf("rnd_eol_x%0d", xidx), out_eol, (mch == 2 && (pix % 24) == 23));
        chk($sformatf("rnd_eof_x%0d", xidx), out_eof, (mch == 2 && (pix % 576) == 575));
      end
      if (prev_stall) begin
        chk("rnd_stall_data", out_data, prev_data);
        chk("rnd_stall_ch", out_ch, prev_ch);
      end
      prev_stall = e_val && !out_ready;
      prev_data = out_data;
      prev_ch = out_ch;
      if (e_val && out_ready) begin
        xidx++;
        if (mch == 2) begin
          mch = 0;
          void'(mq.pop_front());
        end else begin
          mch++;
        end
      end
      if (in_val) begin
        mq.push_back(rnd);
        sent++;
      end
      tick();
    end
    in_val = 1'b0; out_ready = 1'b0;
    chk("rnd_all_sent", sent, 2000);
    chk("rnd_drained", mq.size(), 0);
    chk("rnd_xfer_count", xidx, 6000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
